// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART transmit path.
// Optional even-parity bit is selected with FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 32'd1;
`else
  localparam int unsigned PARITY_BITS = 32'd0;
`endif

  // Total clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned clks_per_bit);
    return (32'd2 + data_width + PARITY_BITS) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status of the UART transmitter.
// master = transmitter, slave = FIFO/line environment.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd_en;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  tx_en, fifo_empty, fifo_rdata,
    output fifo_rd_en, tx, busy, frame_done
  );

  modport slave (
    output tx_en, fifo_empty, fifo_rdata,
    input  fifo_rd_en, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle.
// Held at zero while clear is high so every timed state starts a fresh period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    if (clear || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and sends each as an LSB-first UART frame.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit after the data.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  tx_state_e             state_q;
  logic                  tx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_W-1:0]      bit_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q;
`endif
  logic                  baud_clear;
  logic                  bit_end;

  // Untimed states keep the baud counter at zero, so START always begins a full period.
  assign baud_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  assign bus.fifo_rd_en = (state_q == FETCH);
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == STOP) && bit_end;
  assign bus.tx         = tx_q;

  // Frame sequencer; tx_q is loaded with the level of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= UART_IDLE_LEVEL;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= UART_IDLE_LEVEL;
          if (bus.tx_en && !bus.fifo_empty) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          tx_q    <= UART_IDLE_LEVEL;
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q   <= bus.fifo_rdata;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q  <= ^bus.fifo_rdata;
`endif
          bit_idx_q <= '0;
          tx_q      <= UART_START_LEVEL;
          state_q   <= START;
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_idx_q <= bit_idx_q + BIT_ONE;
            if (bit_idx_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= UART_STOP_LEVEL;
              state_q <= STOP;
`endif
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_q    <= UART_STOP_LEVEL;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            tx_q <= UART_IDLE_LEVEL;
            // Last stop cycle is the only other place the FIFO flag is looked at.
            if (bus.tx_en && !bus.fifo_empty) begin
              state_q <= FETCH;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= UART_IDLE_LEVEL;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
